// File: rtl/add_pkg.sv
// rtl/add_pkg.sv - shared encodings for the limb-serial add/subtract unit
package add_pkg;

  // Operation select as presented on op
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_ADC = 2'b10;
  localparam logic [1:0] OP_SBB = 2'b11;

  // Sequencer states
  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_RUN  = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

  // Bit 0 of op marks the subtracting forms, which add the inverted B operand
  function automatic logic op_inverts_b(input logic [1:0] op_i);
    return op_i[0];
  endfunction

  // Initial carry: 0 for ADD, 1 for SUB, cin for ADC, ~cin for SBB
  function automatic logic op_carry_in(input logic [1:0] op_i, input logic cin_i);
    return op_i[1] ? (cin_i ^ op_i[0]) : op_i[0];
  endfunction

endpackage

// File: rtl/add_limb.sv
// rtl/add_limb.sv - combinational ripple adder for one limb
module add_limb #(
  parameter int W = 8
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  input  logic         ci,
  output logic [W-1:0] s,
  output logic         co,
  output logic         c_msb
);

  // Bitwise ripple; the carry entering the top bit is kept for overflow detection
  always_comb begin
    logic c;
    s     = '0;
    c_msb = 1'b0;
    c     = ci;
    for (int i = 0; i < W; i++) begin
      if (i == W - 1) begin
        c_msb = c;
      end
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (x[i] & c) | (y[i] & c);
    end
    co = c;
  end

endmodule

// File: rtl/add_seq.sv
// rtl/add_seq.sv - multi-cycle add/subtract unit, one limb per clock
module add_seq
  import add_pkg::*;
#(
  parameter int N    = 32,
  parameter int LIMB = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [1:0]   op,
  input  logic         cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] result,
  output logic         carry,
  output logic         overflow,
  output logic         zero,
  output logic         negative
);

  localparam int L  = N / LIMB;
  localparam int IW = (L > 1) ? $clog2(L) : 1;
  localparam logic [IW-1:0] LAST = IW'(L - 1);

  logic [1:0]    state_q, state_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic          c_q, c_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [N-1:0]  result_q, result_d;
  logic          nz_q, nz_d;
  logic          carry_q, carry_d;
  logic          ovf_q, ovf_d;
  logic          zero_q, zero_d;
  logic          neg_q, neg_d;

  logic [LIMB-1:0] limb_s;
  logic            limb_co;
  logic            limb_c_msb;

  // Operand registers shift right each step, so the active limb is always the low slice
  add_limb #(.W(LIMB)) u_limb (
    .x     (a_q[LIMB-1:0]),
    .y     (b_q[LIMB-1:0]),
    .ci    (c_q),
    .s     (limb_s),
    .co    (limb_co),
    .c_msb (limb_c_msb)
  );

  // Next-state: accept in IDLE, one limb per cycle in RUN, hold in DONE until taken
  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    c_d      = c_q;
    idx_d    = idx_q;
    result_d = result_q;
    nz_d     = nz_q;
    carry_d  = carry_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;
    neg_d    = neg_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d      = a;
          b_d      = op_inverts_b(op) ? ~b : b;
          c_d      = op_carry_in(op, cin);
          idx_d    = '0;
          result_d = '0;
          nz_d     = 1'b0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        a_d = a_q >> LIMB;
        b_d = b_q >> LIMB;
        c_d = limb_co;
        result_d[int'(idx_q) * LIMB +: LIMB] = limb_s;
        nz_d  = nz_q | (|limb_s);
        idx_d = idx_q + IW'(1);
        if (idx_q == LAST) begin
          // Signed overflow equals carry into the MSB differing from carry out of it
          carry_d = limb_co;
          ovf_d   = limb_c_msb ^ limb_co;
          zero_d  = ~(nz_q | (|limb_s));
          neg_d   = limb_s[LIMB-1];
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; reset abandons any operation in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      c_q      <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      nz_q     <= 1'b0;
      carry_q  <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      c_q      <= c_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      nz_q     <= nz_d;
      carry_q  <= carry_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign result    = result_q;
  assign carry     = carry_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule
